mul_8bits: RTL and testbench

MUL_8BITS -- requirements
Module: mul_8bits

---
 rtl/mul_8bits.sv | 89 ++++++++
 tb/tb_mul_8bits.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_8bits.sv
// 8x8 pipelined multiplier: operand register, partial-product register, product register.
// Define MUL_8BITS_SIGNED_EN to honour the Signed port; otherwise all operations are unsigned.
module mul_8bits (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        Signed,
    output logic        out_valid,
    output logic [15:0] Prod
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned NUM_PP = 8;

    logic              sgn_c;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic              sgn_q;
    logic              s1_vld;
    logic              s2_vld;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] a_neg;
    logic [PROD_W-1:0] pp_c [NUM_PP];
    logic [PROD_W-1:0] pp_q [NUM_PP];
    logic [PROD_W-1:0] sum_c;

`ifdef MUL_8BITS_SIGNED_EN
    assign sgn_c = Signed;
`else
    logic unused_signed;
    assign unused_signed = Signed;
    assign sgn_c         = 1'b0;
`endif

    // Valid tracking and output register; reset flushes every in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            Prod      <= '0;
        end else begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (s2_vld) begin
                Prod <= sum_c;
            end
        end
    end

    // Data registers only move when their stage holds a live operation.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            sgn_q <= sgn_c;
        end
        if (s1_vld) begin
            pp_q <= pp_c;
        end
    end

    // B's MSB carries weight -128 in signed mode, so its row uses -A.
    always_comb begin
        a_ext = sgn_q ? {{(PROD_W-OP_W){a_q[OP_W-1]}}, a_q} : {(PROD_W-OP_W)'(0), a_q};
        a_neg = ~a_ext + PROD_W'(1);
        for (int i = 0; i < NUM_PP; i++) begin
            pp_c[i] = '0;
        end
        for (int i = 0; i < NUM_PP - 1; i++) begin
            pp_c[i] = b_q[i] ? (a_ext << i) : '0;
        end
        pp_c[NUM_PP-1] = b_q[OP_W-1] ? ((sgn_q ? a_neg : a_ext) << (NUM_PP - 1)) : '0;
    end

    // Modulo-2^16 sum of the rows is exact for both operand modes.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            sum_c = sum_c + pp_q[i];
        end
    end

endmodule

// File: tb/tb_mul_8bits.sv
// Directed bench for mul_8bits: hand-computed products checked cycle by cycle
// against an expected-result queue and a two-cycle valid pipeline.
module tb_mul_8bits;

`ifdef MUL_8BITS_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        Signed;
    logic        out_valid;
    logic [15:0] Prod;

    int          checks;
    int          errors;
    bit          mon_en;

    logic [15:0] cur_exp;
    logic [15:0] expq[$];
    logic        s1;
    logic        s2;
    logic        out_e;
    logic [15:0] prod_m;

    mul_8bits dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Signed    (Signed),
        .out_valid (out_valid),
        .Prod      (Prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected behaviour: accepted op appears two edges later; reset flushes everything.
    always @(posedge clk) begin
        if (rst) begin
            s1     = 1'b0;
            s2     = 1'b0;
            out_e  = 1'b0;
            prod_m = 16'h0000;
            expq.delete();
        end else begin
            out_e = s2;
            s2    = s1;
            s1    = in_valid;
            if (in_valid) expq.push_back(cur_exp);
            if (out_e && expq.size() > 0) prod_m = expq.pop_front();
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", {15'b0, out_valid}, {15'b0, out_e});
            check("prod", Prod, prod_m);
        end
    end

    // eu: unsigned result, es: two's-complement result.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] eu, input logic [15:0] es);
        @(negedge clk);
        A        = a;
        B        = b;
        Signed   = s;
        in_valid = 1'b1;
        cur_exp  = (SEN && s) ? es : eu;
    endtask

    // Idle cycles present junk operands that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A        = 8'hC3;
            B        = 8'h5A;
            Signed   = ~Signed;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        Signed   = 1'b0;
        cur_exp  = 16'h0000;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(8'd3, 8'd5, 1'b0, 16'h000F, 16'h000F);
        idle(4);

        // sign combinations, back-to-back
        op(8'h03, 8'h05, 1'b1, 16'h000F, 16'h000F);
        op(8'hFD, 8'hFB, 1'b1, 16'hF80F, 16'h000F);
        op(8'hFD, 8'h05, 1'b1, 16'h04F1, 16'hFFF1);
        op(8'h05, 8'hFD, 1'b1, 16'h04F1, 16'hFFF1);
        idle(4);

        // mode contrast with Signed toggling between consecutive ops
        op(8'hFD, 8'h05, 1'b0, 16'h04F1, 16'h04F1);
        op(8'hFD, 8'h05, 1'b1, 16'h04F1, 16'hFFF1);
        op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01);
        op(8'hFF, 8'hFF, 1'b1, 16'hFE01, 16'h0001);
        idle(4);

        // corners
        op(8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000);
        op(8'h80, 8'h7F, 1'b1, 16'h3F80, 16'hC080);
        op(8'h00, 8'hA5, 1'b1, 16'h0000, 16'h0000);
        op(8'h5A, 8'h00, 1'b1, 16'h0000, 16'h0000);
        op(8'h01, 8'h80, 1'b1, 16'h0080, 16'hFF80);
        op(8'h7F, 8'h7F, 1'b1, 16'h3F01, 16'h3F01);
        op(8'h12, 8'h34, 1'b0, 16'h03A8, 16'h03A8);
        idle(4);

        // reset mid-flight, with in_valid held high during reset
        op(8'h07, 8'h09, 1'b0, 16'h003F, 16'h003F);
        op(8'h0B, 8'h0D, 1'b0, 16'h008F, 16'h008F);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 8'h22;
        B        = 8'h33;
        cur_exp  = 16'h06C6;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(3);
        op(8'h06, 8'h07, 1'b0, 16'h002A, 16'h002A);
        idle(5);

        check("drain", 16'(expq.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
